pipelined_shift_unit: RTL

//  Parametrised, pipelined barrel shifter for the ALU shift path: SLL, SRL, SRA, ROR, ROL.
//  log2(WIDTH) registered stages; accepts one operation per cycle.

---
 rtl/shift_pkg.sv | 42 ++++
 rtl/shift_stage.sv | 80 ++++++++
 rtl/pipelined_shift_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the pipelined shift unit: operation encodings,
//   the fill mode carried down the log-shifter stages, and helper functions.
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    // Widest data path bitrev() can handle.
    localparam int unsigned MAX_WIDTH = 64;

    // What a right-shifting stage feeds into the vacated top bits.
    typedef enum logic [1:0] {
        FillZero,
        FillSign,
        FillRot
    } fill_e;

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

    // Reverses the low 'width' bits of d; bits above 'width' must be zero.
    function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] d,
                                                    input int unsigned         width);
        logic [MAX_WIDTH-1:0] r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = d[MAX_WIDTH-1-i];
        end
        return r >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// ----------------------------------------------------------------------------
// shift_stage
//   One registered stage of the right-shift log shifter. When 'en' is set the
//   data is shifted right by DIST with the top bits filled according to
//   fill_in; otherwise it passes through. Fill mode, sign bit and an opaque
//   sideband travel with the data. The whole stage loads only when adv is 1.
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   adv                pipeline advance
//   valid_in/out       slot valid
//   data_in/out        data word
//   fill_in/out        fill mode for vacated bits
//   sign_in/out        sign bit used by FillSign
//   en                 shift enable for this stage (one bit of the amount)
//   side_in/out        sideband piped unchanged
// ----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIST   = 1,
    parameter int unsigned SIDE_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              adv,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  data_in,
    input  fill_e             fill_in,
    input  logic              sign_in,
    input  logic              en,
    input  logic [SIDE_W-1:0] side_in,
    output logic              valid_out,
    output logic [WIDTH-1:0]  data_out,
    output fill_e             fill_out,
    output logic              sign_out,
    output logic [SIDE_W-1:0] side_out
);

    logic [DIST-1:0]   fill_bits;
    logic [WIDTH-1:0]  data_d;

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    fill_e             fill_q;
    logic              sign_q;
    logic [SIDE_W-1:0] side_q;

    always_comb begin
        case (fill_in)
            FillSign: fill_bits = {DIST{sign_in}};
            FillRot:  fill_bits = data_in[DIST-1:0];
            default:  fill_bits = '0;
        endcase
        data_d = en ? {fill_bits, data_in[WIDTH-1:DIST]} : data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            fill_q  <= FillZero;
            sign_q  <= 1'b0;
            side_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_in;
            data_q  <= data_d;
            fill_q  <= fill_in;
            sign_q  <= sign_in;
            side_q  <= side_in;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign fill_out  = fill_q;
    assign sign_out  = sign_q;
    assign side_out  = side_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// ----------------------------------------------------------------------------
// pipelined_shift_unit
//   Pipelined barrel shifter (SLL, SRL, SRA, ROR, ROL) with SHAMT_W registered
//   log stages, one operation per cycle, valid/ready on both sides. Left ops
//   are bit-reversed on entry and exit so every stage only shifts right.
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   op                 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, else illegal
//   data_in, shamt     operand and shift amount
//   out_valid/ready    output handshake
//   data_out           result
//   carry              last bit shifted/rotated out, 0 for a zero amount
//   zero               data_out == 0
//   illegal            result came from an illegal op (data_out and carry 0)
// ----------------------------------------------------------------------------
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               carry,
    output logic               zero,
    output logic               illegal
);

    // Sideband layout: {op, carry, shamt}.
    localparam int unsigned SIDE_W = 3 + 1 + SHAMT_W;

    logic               adv;
    logic [WIDTH-1:0]   entry_data;
    fill_e              entry_fill;
    logic               entry_carry;
    logic [SIDE_W-1:0]  entry_side;

    logic               valid_c [SHAMT_W];
    logic [WIDTH-1:0]   data_c  [SHAMT_W];
    fill_e              fill_c  [SHAMT_W];
    logic               sign_c  [SHAMT_W];
    logic [SIDE_W-1:0]  side_c  [SHAMT_W];

    logic [WIDTH-1:0]   last_data;
    logic [SIDE_W-1:0]  last_side;
    logic [2:0]         last_op;
    logic               unused_last;

    // The whole pipeline moves unless a result is waiting on the consumer.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        entry_data = '0;
        if (is_legal(op)) begin
            entry_data = is_left(op) ? WIDTH'(bitrev(MAX_WIDTH'(data_in), WIDTH)) : data_in;
        end

        case (op)
            OP_SRA:         entry_fill = FillSign;
            OP_ROR, OP_ROL: entry_fill = FillRot;
            default:        entry_fill = FillZero;
        endcase

        // In the right-shift domain (left ops already reversed) the last bit
        // out is always bit s-1; illegal ops have zero data so carry is 0.
        entry_carry = (shamt != '0) ? entry_data[shamt - SHAMT_W'(1)] : 1'b0;
        entry_side  = {op, entry_carry, shamt};
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic              v_in;
        logic [WIDTH-1:0]  d_in;
        fill_e             f_in;
        logic              s_in;
        logic [SIDE_W-1:0] sd_in;

        if (k == 0) begin : g_first
            assign v_in  = in_valid;
            assign d_in  = entry_data;
            assign f_in  = entry_fill;
            assign s_in  = data_in[WIDTH-1];
            assign sd_in = entry_side;
        end else begin : g_rest
            assign v_in  = valid_c[k-1];
            assign d_in  = data_c[k-1];
            assign f_in  = fill_c[k-1];
            assign s_in  = sign_c[k-1];
            assign sd_in = side_c[k-1];
        end

        shift_stage #(
            .WIDTH  (WIDTH),
            .DIST   (1 << k),
            .SIDE_W (SIDE_W)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .adv       (adv),
            .valid_in  (v_in),
            .data_in   (d_in),
            .fill_in   (f_in),
            .sign_in   (s_in),
            .en        (sd_in[k]),
            .side_in   (sd_in),
            .valid_out (valid_c[k]),
            .data_out  (data_c[k]),
            .fill_out  (fill_c[k]),
            .sign_out  (sign_c[k]),
            .side_out  (side_c[k])
        );
    end

    assign out_valid = valid_c[SHAMT_W-1];
    assign last_data = data_c[SHAMT_W-1];
    assign last_side = side_c[SHAMT_W-1];
    assign last_op   = last_side[SIDE_W-1 -: 3];

    assign unused_last = ^{fill_c[SHAMT_W-1], sign_c[SHAMT_W-1], last_side[SHAMT_W-1:0]};

    // Outputs read as reset values whenever no result is presented.
    always_comb begin
        data_out = '0;
        carry    = 1'b0;
        illegal  = 1'b0;
        if (out_valid) begin
            data_out = is_left(last_op) ? WIDTH'(bitrev(MAX_WIDTH'(last_data), WIDTH))
                                        : last_data;
            carry    = last_side[SHAMT_W];
            illegal  = !is_legal(last_op);
        end
        zero = (data_out == '0);
    end

endmodule
